// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with occupancy count, full/empty/almost flags and overflow/underflow pulses.
// Latency: standard mode, data_out is valid the cycle after an accepted read; FWFT mode, a word
//          written into an empty FIFO is on data_out the cycle after its write edge.
// Backpressure: a write while full is dropped (overflow pulses); a read while empty is dropped
//               (underflow pulses); nothing stalls.
//
// Ports:
//   clk, rst        single clock, asynchronous active-low reset
//   wr_en, data_in  write request and data
//   rd_en           read request (FWFT: acknowledge of the head word)
//   data_out        read data (registered in standard mode, head word in FWFT mode)
//   full, empty, almost_full, almost_empty   decoded from the count register
//   count           stored words, 0..DEPTH
//   overflow, underflow   one-cycle pulses for rejected write / read
module sync_fifo_flags #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Thresholds widened once to the count width; CW bits hold DEPTH itself.
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_acc;
  logic             rd_acc;

  // Flags depend only on the count register, so there is no combinational
  // path from the request inputs to any flag.
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // Acceptance is judged against the occupancy before the edge. This alone
  // gives the simultaneous cases: when full only the read goes through,
  // when empty only the write goes through, otherwise both.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  // Pointers are exactly AW bits; DEPTH is a power of two, so the natural
  // binary rollover is the wrap from DEPTH-1 to 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      overflow  <= wr_en & full;
      underflow <= rd_en & empty;
    end
  end

  // Storage carries no reset: stale words are unreachable once the pointers
  // and count are cleared.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  generate
    if (FWFT == 0) begin : g_std
      // Output register loads the head word on an accepted read and holds
      // across idle cycles and rejected reads.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          data_out <= '0;
        end else if (rd_acc) begin
          data_out <= mem[rd_ptr];
        end
      end
    end else begin : g_fwft
      // The head word is always presented. A write into an empty FIFO lands
      // at rd_ptr, so it shows up right after its write edge with no extra
      // staging; the value while empty is meaningless.
      assign data_out = mem[rd_ptr];
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
module tb_sync_fifo_flags;
  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // standard-read instance
  logic          rst0 = 1'b1;
  logic          we0 = 1'b0, re0 = 1'b0;
  logic [7:0]    din0 = '0, dout0;
  logic          full0, empty0, af0, ae0, ovf0, udf0;
  logic [CW-1:0] cnt0;

  // first-word-fall-through instance
  logic          rst1 = 1'b1;
  logic          we1 = 1'b0, re1 = 1'b0;
  logic [7:0]    din1 = '0, dout1;
  logic          full1, empty1, af1, ae1, ovf1, udf1;
  logic [CW-1:0] cnt1;

  sync_fifo_flags #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_std (
    .clk(clk), .rst(rst0), .wr_en(we0), .rd_en(re0), .data_in(din0), .data_out(dout0),
    .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(cnt0), .overflow(ovf0), .underflow(udf0));

  sync_fifo_flags #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst1), .wr_en(we1), .rd_en(re1), .data_in(din1), .data_out(dout1),
    .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(cnt1), .overflow(ovf1), .underflow(udf1));

  // Reference model: a queue of stored words plus the last word read out.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] exp_dout0 = '0;
  logic       exp_ovf0 = 1'b0, exp_udf0 = 1'b0;
  logic       exp_ovf1 = 1'b0, exp_udf1 = 1'b0;

  task automatic model0(input logic we, input logic re, input logic [7:0] d);
    int n = q0.size();
    exp_ovf0 = we && (n == DEPTH);
    exp_udf0 = re && (n == 0);
    if (re && n != 0) exp_dout0 = q0.pop_front();
    if (we && n != DEPTH) q0.push_back(d);
  endtask

  task automatic model1(input logic we, input logic re, input logic [7:0] d);
    int n = q1.size();
    exp_ovf1 = we && (n == DEPTH);
    exp_udf1 = re && (n == 0);
    if (re && n != 0) void'(q1.pop_front());
    if (we && n != DEPTH) q1.push_back(d);
  endtask

  // One clock on each instance: inputs applied 1 time unit after an edge,
  // outputs observed 1 time unit after the next edge.
  task automatic cyc0(input logic we, input logic re, input logic [7:0] d);
    we0 = we; re0 = re; din0 = d;
    @(posedge clk);
    model0(we, re, d);
    #1;
  endtask

  task automatic cyc1(input logic we, input logic re, input logic [7:0] d);
    we1 = we; re1 = re; din1 = d;
    @(posedge clk);
    model1(we, re, d);
    #1;
  endtask

  task automatic test_reset;
    #2;
    rst0 = 1'b0;
    rst1 = 1'b0;
    #1;
    checks++; if (cnt0 !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", cnt0); end
    checks++; if ({empty0, ae0, full0, af0} !== 4'b1100) begin errors++; $display("FAIL reset_flags got=%b exp=1100 (empty,ae,full,af)", {empty0, ae0, full0, af0}); end
    checks++; if ({ovf0, udf0} !== 2'b00) begin errors++; $display("FAIL reset_pulses got=%b exp=00", {ovf0, udf0}); end
    checks++; if (dout0 !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h exp=00", dout0); end
    checks++; if ({cnt1, empty1, full1} !== {5'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL reset_fwft got cnt=%0d empty=%b full=%b exp 0 1 0", cnt1, empty1, full1); end
    @(negedge clk);
    rst0 = 1'b1;
    rst1 = 1'b1;
    @(posedge clk);
    model0(1'b0, 1'b0, 8'h00);
    model1(1'b0, 1'b0, 8'h00);
    #1;
  endtask

  task automatic test_fill;
    for (int i = 1; i <= 16; i++) begin
      cyc0(1'b1, 1'b0, 8'(i));
      checks++; if (cnt0 !== CW'(i)) begin errors++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, cnt0, i); end
      checks++; if (empty0 !== 1'b0) begin errors++; $display("FAIL fill_empty i=%0d got=%b exp=0", i, empty0); end
      checks++; if (af0 !== (i >= 14)) begin errors++; $display("FAIL fill_af i=%0d got=%b exp=%b", i, af0, i >= 14); end
      checks++; if (full0 !== (i == 16)) begin errors++; $display("FAIL fill_full i=%0d got=%b exp=%b", i, full0, i == 16); end
      checks++; if (ae0 !== (i <= 2)) begin errors++; $display("FAIL fill_ae i=%0d got=%b exp=%b", i, ae0, i <= 2); end
    end
  endtask

  task automatic test_overflow;
    cyc0(1'b1, 1'b0, 8'hAA);
    checks++; if (ovf0 !== 1'b1) begin errors++; $display("FAIL ovf_pulse got=%b exp=1", ovf0); end
    checks++; if (cnt0 !== 5'd16) begin errors++; $display("FAIL ovf_count got=%0d exp=16", cnt0); end
    cyc0(1'b0, 1'b0, 8'h00);
    checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL ovf_one_cycle got=%b exp=0", ovf0); end
    for (int i = 1; i <= 16; i++) begin
      cyc0(1'b0, 1'b1, 8'h00);
      checks++; if (dout0 !== 8'(i)) begin errors++; $display("FAIL ovf_drain i=%0d got=%h exp=%h", i, dout0, 8'(i)); end
    end
    checks++; if ({empty0, cnt0} !== {1'b1, 5'd0}) begin errors++; $display("FAIL ovf_end got empty=%b cnt=%0d exp 1 0", empty0, cnt0); end
  endtask

  task automatic test_wrap;
    logic [7:0] exp_seq[$];
    for (int i = 1; i <= 16; i++) cyc0(1'b1, 1'b0, 8'(i));
    for (int i = 1; i <= 5; i++) begin
      cyc0(1'b0, 1'b1, 8'h00);
      checks++; if (dout0 !== 8'(i)) begin errors++; $display("FAIL wrap_read5 i=%0d got=%h exp=%h", i, dout0, 8'(i)); end
    end
    for (int i = 0; i < 4; i++) cyc0(1'b1, 1'b0, 8'h21 + 8'(i));
    checks++; if (cnt0 !== 5'd15) begin errors++; $display("FAIL wrap_count got=%0d exp=15", cnt0); end
    for (int i = 6; i <= 16; i++) exp_seq.push_back(8'(i));
    for (int i = 0; i < 4; i++) exp_seq.push_back(8'h21 + 8'(i));
    for (int i = 0; i < 15; i++) begin
      cyc0(1'b0, 1'b1, 8'h00);
      checks++; if (dout0 !== exp_seq[i]) begin errors++; $display("FAIL wrap_read15 i=%0d got=%h exp=%h", i, dout0, exp_seq[i]); end
    end
    checks++; if ({empty0, cnt0} !== {1'b1, 5'd0}) begin errors++; $display("FAIL wrap_end got empty=%b cnt=%0d exp 1 0", empty0, cnt0); end
  endtask

  task automatic test_underflow;
    cyc0(1'b0, 1'b1, 8'h00);
    checks++; if (udf0 !== 1'b1) begin errors++; $display("FAIL udf_pulse got=%b exp=1", udf0); end
    checks++; if (cnt0 !== 5'd0) begin errors++; $display("FAIL udf_count got=%0d exp=0", cnt0); end
    checks++; if (dout0 !== 8'h24) begin errors++; $display("FAIL udf_dout_hold got=%h exp=24", dout0); end
    cyc0(1'b0, 1'b0, 8'h00);
    checks++; if (udf0 !== 1'b0) begin errors++; $display("FAIL udf_one_cycle got=%b exp=0", udf0); end
  endtask

  task automatic test_simultaneous;
    for (int i = 0; i < 16; i++) cyc0(1'b1, 1'b0, 8'h40 + 8'(i));
    cyc0(1'b1, 1'b1, 8'hBB);
    checks++; if (cnt0 !== 5'd15) begin errors++; $display("FAIL simul_full_count got=%0d exp=15", cnt0); end
    checks++; if (ovf0 !== 1'b1) begin errors++; $display("FAIL simul_full_ovf got=%b exp=1", ovf0); end
    checks++; if (dout0 !== 8'h40) begin errors++; $display("FAIL simul_full_dout got=%h exp=40", dout0); end
    for (int i = 0; i < 15; i++) cyc0(1'b0, 1'b1, 8'h00);
    checks++; if (dout0 !== 8'h4F) begin errors++; $display("FAIL simul_no_bb got=%h exp=4f", dout0); end
    cyc0(1'b1, 1'b1, 8'hCC);
    checks++; if (cnt0 !== 5'd1) begin errors++; $display("FAIL simul_empty_count got=%0d exp=1", cnt0); end
    checks++; if (udf0 !== 1'b1) begin errors++; $display("FAIL simul_empty_udf got=%b exp=1", udf0); end
    for (int i = 0; i < 7; i++) cyc0(1'b1, 1'b0, 8'hD0 + 8'(i));
    cyc0(1'b1, 1'b1, 8'hE0);
    checks++; if (cnt0 !== 5'd8) begin errors++; $display("FAIL simul_mid_count got=%0d exp=8", cnt0); end
    checks++; if ({ovf0, udf0} !== 2'b00) begin errors++; $display("FAIL simul_mid_pulses got=%b exp=00", {ovf0, udf0}); end
    checks++; if (dout0 !== 8'hCC) begin errors++; $display("FAIL simul_mid_dout got=%h exp=cc", dout0); end
    while (q0.size() != 0) begin
      cyc0(1'b0, 1'b1, 8'h00);
      checks++; if (dout0 !== exp_dout0) begin errors++; $display("FAIL simul_drain got=%h exp=%h", dout0, exp_dout0); end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 600; i++) begin
      int n;
      logic we, re;
      if (((i / 60) % 2) == 0) begin
        we = ($urandom_range(0, 99) < 75);
        re = ($urandom_range(0, 99) < 35);
      end else begin
        we = ($urandom_range(0, 99) < 35);
        re = ($urandom_range(0, 99) < 75);
      end
      cyc0(we, re, 8'($urandom));
      n = q0.size();
      checks++; if (cnt0 !== CW'(n)) begin errors++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, cnt0, n); end
      checks++; if ({full0, empty0, af0, ae0} !== {n == 16, n == 0, n >= 14, n <= 2}) begin errors++; $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", i, {full0, empty0, af0, ae0}, {n == 16, n == 0, n >= 14, n <= 2}); end
      checks++; if ({ovf0, udf0} !== {exp_ovf0, exp_udf0}) begin errors++; $display("FAIL rnd_pulses cyc=%0d got=%b exp=%b", i, {ovf0, udf0}, {exp_ovf0, exp_udf0}); end
      checks++; if (dout0 !== exp_dout0) begin errors++; $display("FAIL rnd_dout cyc=%0d got=%h exp=%h", i, dout0, exp_dout0); end
    end
    cyc0(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 5; i++) cyc0(1'b1, 1'b0, 8'h60 + 8'(i));
    #2;
    rst0 = 1'b0;
    #1;
    q0.delete();
    exp_dout0 = 8'h00;
    checks++; if ({cnt0, empty0, ae0, full0, af0} !== {5'd0, 4'b1100}) begin errors++; $display("FAIL rstmid_state got cnt=%0d flags=%b exp 0 1100", cnt0, {empty0, ae0, full0, af0}); end
    checks++; if (dout0 !== 8'h00) begin errors++; $display("FAIL rstmid_dout got=%h exp=00", dout0); end
    @(negedge clk);
    rst0 = 1'b1;
    cyc0(1'b1, 1'b0, 8'h77);
    checks++; if (cnt0 !== 5'd1) begin errors++; $display("FAIL rstmid_first_write got=%0d exp=1", cnt0); end
    cyc0(1'b0, 1'b1, 8'h00);
    checks++; if (dout0 !== 8'h77) begin errors++; $display("FAIL rstmid_readback got=%h exp=77", dout0); end
    cyc0(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_fwft;
    cyc1(1'b1, 1'b0, 8'h5A);
    cyc1(1'b0, 1'b0, 8'h00);
    checks++; if (dout1 !== 8'h5A) begin errors++; $display("FAIL fwft_first got=%h exp=5a", dout1); end
    checks++; if (empty1 !== 1'b0) begin errors++; $display("FAIL fwft_empty got=%b exp=0", empty1); end
    for (int i = 0; i < 300; i++) begin
      int n;
      cyc1($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, 8'($urandom));
      n = q1.size();
      checks++; if (cnt1 !== CW'(n)) begin errors++; $display("FAIL fwft_count cyc=%0d got=%0d exp=%0d", i, cnt1, n); end
      checks++; if ({ovf1, udf1} !== {exp_ovf1, exp_udf1}) begin errors++; $display("FAIL fwft_pulses cyc=%0d got=%b exp=%b", i, {ovf1, udf1}, {exp_ovf1, exp_udf1}); end
      if (n != 0) begin
        checks++; if (dout1 !== q1[0]) begin errors++; $display("FAIL fwft_head cyc=%0d got=%h exp=%h", i, dout1, q1[0]); end
      end
    end
    while (q1.size() != 0) cyc1(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 7; i++) begin
      cyc1(1'b1, 1'b0, 8'h90 + 8'(i));
      checks++; if (dout1 !== 8'h90) begin errors++; $display("FAIL fwft_burst_head i=%0d got=%h exp=90", i, dout1); end
    end
    checks++; if (cnt1 !== 5'd7) begin errors++; $display("FAIL fwft_burst_count got=%0d exp=7", cnt1); end
    we1 = 1'b1; din1 = 8'h97;
    #2;
    rst1 = 1'b0;
    #1;
    q1.delete();
    checks++; if ({cnt1, empty1} !== {5'd0, 1'b1}) begin errors++; $display("FAIL fwft_async_reset got cnt=%0d empty=%b exp 0 1", cnt1, empty1); end
    we1 = 1'b0;
    @(negedge clk);
    rst1 = 1'b1;
    cyc1(1'b1, 1'b0, 8'h3C);
    checks++; if ({cnt1, dout1} !== {5'd1, 8'h3C}) begin errors++; $display("FAIL fwft_after_reset got cnt=%0d dout=%h exp 1 3c", cnt1, dout1); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_wrap();
    test_underflow();
    test_simultaneous();
    test_random();
    test_reset_mid();
    test_fwft();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
